booth_ctrl: RTL

Sequencing controller for the 16-bit radix-2 sequential Booth multiplier. It drives the iteration counter through its load and decrement strobes, consumes the counter's `count` value, and issues the load, clear, add/subtract and shift strobes to the accumulator (A), multiplier (Q), multiplicand (M) and Q(-1) flip-flop datapath. It exposes a start/busy/done handshake to the enclosing DCT stage.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_step_decode.sv | 16 +
 rtl/booth_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_pkg;

  localparam int BOOTH_N     = 16;
  localparam int BOOTH_CNT_W = 5;

  localparam logic BOOTH_OP_ADD = 1'b1;
  localparam logic BOOTH_OP_SUB = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    EVAL,
    ADDSUB,
    SHIFT,
    DONE
  } booth_state_t;

endpackage

// File: rtl/booth_step_decode.sv
// Radix-2 Booth recoding of {Q[0], Q(-1)}: whether an add/subtract step is
// needed and which one. Shared with the radix-4 controller.
module booth_step_decode
  import booth_pkg::*;
(
  input  logic [1:0] qbits_i,
  output logic       need_op_o,
  output logic       addsub_o
);

  always_comb begin
    need_op_o = qbits_i[1] ^ qbits_i[0];
    addsub_o  = (qbits_i == 2'b01) ? BOOTH_OP_ADD : BOOTH_OP_SUB;
  end

endmodule

// File: rtl/booth_ctrl.sv
// Sequencing FSM for the 16-bit sequential Booth multiplier datapath.
// Optional BOOTH_CTRL_ABORT_EN adds an 'abort' input that returns to IDLE.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N     = BOOTH_N,
  parameter int CNT_W = BOOTH_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef BOOTH_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  input  logic [CNT_W-1:0] count,
  output logic             ldA,
  output logic             clrA,
  output logic             ldQ,
  output logic             ldM,
  output logic             clrff,
  output logic             addsub,
  output logic             sftA,
  output logic             sftQ,
  output logic             ldcnt,
  output logic             decr,
  output logic             busy,
  output logic             done
);

  if (CNT_W != $clog2(N) + 1) begin : g_cnt_w_check
    $error("booth_ctrl: CNT_W must equal $clog2(N)+1");
  end

  booth_state_t state_q, state_d;
  logic [1:0]   opBits_q, opBits_d;
  logic         needOpLive, addsubLive;
  logic         needOpReg, addsubReg;

  // Live decode steers the EVAL branch; the registered copy drives ADDSUB.
  booth_step_decode u_dec_live (
    .qbits_i   ({q0, qm1}),
    .need_op_o (needOpLive),
    .addsub_o  (addsubLive)
  );

  booth_step_decode u_dec_reg (
    .qbits_i   (opBits_q),
    .need_op_o (needOpReg),
    .addsub_o  (addsubReg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opBits_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      opBits_q <= opBits_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opBits_d = opBits_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_M;
      LOAD_M:  state_d = LOAD_Q;
      LOAD_Q:  state_d = EVAL;
      EVAL: begin
        opBits_d = {q0, qm1};
        state_d  = needOpLive ? ADDSUB : SHIFT;
      end
      ADDSUB:  state_d = SHIFT;
      // The counter has already decremented on this cycle's falling edge.
      SHIFT:   state_d = (count == '0) ? DONE : EVAL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef BOOTH_CTRL_ABORT_EN
    if (abort && (state_q != IDLE)) state_d = IDLE;
`endif
  end

  always_comb begin
    ldA    = 1'b0;
    clrA   = 1'b0;
    ldQ    = 1'b0;
    ldM    = 1'b0;
    clrff  = 1'b0;
    addsub = 1'b0;
    sftA   = 1'b0;
    sftQ   = 1'b0;
    ldcnt  = 1'b0;
    decr   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      LOAD_M: begin
        busy  = 1'b1;
        ldM   = 1'b1;
        clrA  = 1'b1;
        clrff = 1'b1;
        ldcnt = 1'b1;
      end
      LOAD_Q: begin
        busy = 1'b1;
        ldQ  = 1'b1;
      end
      EVAL:   busy = 1'b1;
      ADDSUB: begin
        busy   = 1'b1;
        ldA    = needOpReg;
        addsub = needOpReg & addsubReg;
      end
      SHIFT: begin
        busy = 1'b1;
        sftA = 1'b1;
        sftQ = 1'b1;
        decr = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
